// File: rtl/master_out_port_pkg.sv
// Shared definitions for the master serial transmit port and its slave-side peer.
package master_out_port_pkg;

    localparam int unsigned MOP_ADDR_WIDTH = 12;
    localparam int unsigned MOP_DATA_WIDTH = 8;
    localparam int unsigned MOP_TIMEOUT    = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/master_out_port_piso_shift.sv
// Parallel-load, LSB-first shift register; the current LSB is the serial bit.
module master_out_port_piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out_c
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= par_in;
        end else if (shift) begin
            sreg <= sreg >> 1;
        end
    end

    assign ser_out_c = sreg[0];

endmodule

// File: rtl/master_out_port.sv
// Master transmit port: valid/ready request, then LSB-first serial address and data.
module master_out_port
    import master_out_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MOP_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MOP_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = MOP_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] in_address,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  slave_ready,
    output logic                  master_valid,
    output logic                  tx_address,
    output logic                  tx_data,
    output logic                  write_en,
    output logic                  read_en,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  timeout
);

    localparam int unsigned CNT_W  = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_e              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                mode_q;

    logic                load_c;
    logic                shift_c;
    logic                handshake_c;
    logic                last_bit_c;
    logic [CNT_W-1:0]    next_idx_c;
    logic                data_valid_c;
    logic                addr_bit_c;
    logic                data_bit_c;

    assign load_c      = (state == ST_IDLE) && start;
    assign handshake_c = (state == ST_REQ) && master_valid && slave_ready;
    assign last_bit_c  = (bit_cnt == CNT_W'(ADDR_WIDTH - 1));
    assign shift_c     = handshake_c || ((state == ST_SEND) && !last_bit_c);

    // Index of the bit loaded onto the lines at this edge: 0 at the handshake.
    assign next_idx_c   = (state == ST_SEND) ? (bit_cnt + CNT_W'(1)) : '0;
    assign data_valid_c = mode_q && ({1'b0, next_idx_c} < (CNT_W + 1)'(DATA_WIDTH));

    master_out_port_piso_shift #(.WIDTH(ADDR_WIDTH)) u_addr_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .shift     (shift_c),
        .par_in    (in_address),
        .ser_out_c (addr_bit_c)
    );

    master_out_port_piso_shift #(.WIDTH(DATA_WIDTH)) u_data_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .shift     (shift_c),
        .par_in    (in_data),
        .ser_out_c (data_bit_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            mode_q       <= 1'b0;
            master_valid <= 1'b0;
            tx_address   <= 1'b0;
            tx_data      <= 1'b0;
            write_en     <= 1'b0;
            read_en      <= 1'b0;
            busy         <= 1'b0;
            tx_done      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_REQ;
                        mode_q       <= mode;
                        wait_cnt     <= '0;
                        master_valid <= 1'b1;
                        write_en     <= mode;
                        read_en      <= !mode;
                        busy         <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (handshake_c) begin
                        state        <= ST_SEND;
                        bit_cnt      <= '0;
                        master_valid <= 1'b0;
                        tx_address   <= addr_bit_c;
                        tx_data      <= data_valid_c & data_bit_c;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        state        <= ST_IDLE;
                        timeout      <= 1'b1;
                        master_valid <= 1'b0;
                        write_en     <= 1'b0;
                        read_en      <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (last_bit_c) begin
                        state      <= ST_DONE;
                        tx_address <= 1'b0;
                        tx_data    <= 1'b0;
                        tx_done    <= 1'b1;
                        write_en   <= 1'b0;
                        read_en    <= 1'b0;
                    end else begin
                        bit_cnt    <= bit_cnt + CNT_W'(1);
                        tx_address <= addr_bit_c;
                        tx_data    <= data_valid_c & data_bit_c;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
